piggy_bank_multi: RTL and testbench
===================================

# piggy_bank_multi

Parametrised coin-bank core: NUM_CH debounced coin inputs, each driving a saturating CNT_W-bit counter. The core streams a snapshot report over an 8N1 UART whenever a count changes, a clear occurs, or a report is requested. It is the next-generation replacement for the fixed 4-channel counter, debouncer and UART report path. It sits directly between the pad inputs and the UART TX pin.

## Interface
- NUM_CH, 4: number of coin channels (1..8)
- CNT_W, 8: counter width; multiple of 4, range 4..16
- DEB_CYCLES, 16: consecutive stable cycles required before the debounced level changes (>=2)
- CLKS_PER_BIT, 87: clocks per UART bit (>=4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  enable. When low, coin edges, report_req edges and clear_req are ignored; an in-flight frame completes.
- coin_in  in  NUM_CH  raw asynchronous coin pulses, one bit per channel
- report_req  in  1  raw asynchronous report button
- clear_req  in  1  synchronous single-cycle clear of all counters
- counts  out  NUM_CH*CNT_W  live counts; channel i is at bits [i*CNT_W +: CNT_W]
- sat  out  NUM_CH  sticky per-channel saturation flags
- o_Tx_Active  out  1  high for the whole report frame
- o_Tx_Done  out  1  one-cycle pulse after the final stop bit of a frame
- o_Tx_Serial  out  1  UART line; idle high

## Operation
- Input conditioning (each coin_in bit and report_req):
  - 2-FF synchroniser, then a stability counter.
  - The debounced level takes the synchronised value on the cycle that value has been stable for DEB_CYCLES consecutive cycles.
  - A rising edge of the debounced level produces a one-cycle event.
- Counting:
  - A coin event with ena=1 increments its counter by 1 on the next clock.
  - At 2^CNT_W-1 the counter holds its value and sat[i] is set. sat[i] is cleared only by clear_req or reset.
- clear_req with ena=1 zeroes all counters and sat on the next clock. Clear beats a same-cycle coin event; that event is discarded.
- Report triggering:
  - Any counter change, any clear, or a report_req event sets a `pending` flag. A counter held at saturation does not count as a change.
  - Multiple triggers coalesce into a single pending flag.
- TX FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (NEXT -> START | DONE) -> IDLE.
  - IDLE: when pending=1, go to LOAD.
  - LOAD: snapshot all counts into a shadow register; clear pending; set byte index to 0.
  - START / DATA / STOP: one byte as 8N1, LSB first.
  - NEXT: advance the byte index. If more bytes remain, return to START with no idle gap.
  - DONE: pulse o_Tx_Done for one cycle, then return to IDLE.
- Frame content, built from the shadow snapshot:
  - Channel 0 first. Each channel is sent as CNT_W/4 uppercase hex ASCII digits, MS nibble first.
  - Channels are separated by ',' (0x2C). The frame ends with CR (0x0D), LF (0x0A).
  - Frame length = NUM_CH*(CNT_W/4) + (NUM_CH-1) + 2 bytes.
- Counts that change during a frame do not alter that frame. They set pending, so exactly one further frame follows.

## Timing
- Reset values: counts=0, sat=0, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, pending=0, FSM=IDLE, debounced levels=0.
- Reset asserted mid-frame returns o_Tx_Serial to 1 and o_Tx_Active to 0 immediately (asynchronous). No partial frame resumes after reset.
- Coin latency: after the raw input goes high cleanly, counts updates DEB_CYCLES+3 clock edges after the first edge that samples it high.
- Trigger to line activity:
  - pending is set on the same edge as the count update.
  - LOAD occurs on the following cycle.
  - The start bit (o_Tx_Serial=0, o_Tx_Active=1) begins on the cycle after LOAD.
- Each bit lasts exactly CLKS_PER_BIT cycles; one byte takes 10*CLKS_PER_BIT cycles.
- o_Tx_Done asserts on the cycle after the last stop-bit cycle. o_Tx_Active falls on the same edge that raises o_Tx_Done.
- Back-to-back frames: with pending=1 at DONE, the next start bit begins 3 cycles after o_Tx_Done (DONE -> IDLE -> LOAD -> START).
- A pulse shorter than DEB_CYCLES stable cycles is never counted.

## Test plan
Parameters for all scenarios: NUM_CH=4, CNT_W=8, DEB_CYCLES=4, CLKS_PER_BIT=8.

- Reset: hold rst_n=0 with random inputs -> counts=0, sat=0, o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0. Deassert reset with quiet inputs -> line stays idle.
- Single coin: coin_in[2] high for 10 cycles ->
  - counts ch2=0x01 at DEB_CYCLES+3 edges;
  - frame bytes "00,00,01,00\r\n" (13 bytes);
  - o_Tx_Done pulses 1040 cycles after the start bit begins.
- Bounce rejection: coin_in[1] glitches high for 3 cycles, 5 times -> counts unchanged, no frame. A clean 6-cycle pulse -> ch1 increments exactly once.
- Saturation and clear:
  - 256 clean pulses on ch0 -> ch0=0xFF, sat[0]=1.
  - 257th pulse -> no change, no new trigger.
  - clear_req in the same cycle as a ch3 coin event -> all counts 0, sat=0, one frame "00,00,00,00\r\n".
- Coalescing: three coins on ch1 arrive during a frame -> the current frame is unchanged; exactly one following frame shows ch1=0x03, starting 3 cycles after o_Tx_Done.
- Enable/report:
  - With ena=0, coin pulses -> no count, no frame.
  - With ena=1, a report_req pulse with no count change -> one frame carrying the current values.
  - Reset mid-frame -> line returns high at once; no further bytes.

Source files
------------

// File: rtl/piggy_bank_multi.sv
// Multi-channel coin bank: debounced coin inputs feed saturating counters, and
// a snapshot of all counts is streamed over 8N1 UART as comma-separated hex.
module piggy_bank_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int DEB_CYCLES   = 16,
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NUM_CH-1:0]       coin_in,
  input  logic                    report_req,
  input  logic                    clear_req,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [NUM_CH-1:0]       sat,
  output logic                    o_Tx_Active,
  output logic                    o_Tx_Done,
  output logic                    o_Tx_Serial
);

  localparam int NUM_IN = NUM_CH + 1;
  localparam int DIG    = CNT_W / 4;
  localparam int DW     = $clog2(DEB_CYCLES + 1);
  localparam int BW     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [BW-1:0]    BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]    STOP_LAST = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
  } tx_state_t;

  logic [NUM_IN-1:0] raw, sync1, sync2, deb, deb_q, rise;
  logic [DW-1:0]     stab [NUM_IN];
  logic [NUM_CH-1:0] coin_ev;
  logic              report_ev;

  assign raw       = {report_req, coin_in};
  assign rise      = deb & ~deb_q;
  assign coin_ev   = rise[NUM_CH-1:0];
  assign report_ev = rise[NUM_CH];

  // Debounced level follows the synchronised input only after it has differed
  // from the current level for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NUM_IN; i++) stab[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == deb[i]) begin
          stab[i] <= '0;
        end else if (stab[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          stab[i] <= '0;
        end else begin
          stab[i] <= stab[i] + DW'(1);
        end
      end
    end
  end

  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] bump;
  logic              do_clear, trig;

  assign do_clear = ena & clear_req;

  always_comb begin
    bump = '0;
    for (int i = 0; i < NUM_CH; i++)
      bump[i] = ena && !clear_req && coin_ev[i] && (cnt[i] != CNT_MAX);
  end

  // A counter already at its ceiling produces no bump, so it cannot retrigger a report.
  assign trig = do_clear | (|bump) | (ena & report_ev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (do_clear) begin
      sat <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bump[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
          if (cnt[i] == CNT_MAX - 1'b1) sat[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_counts
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
  end

  tx_state_t               state, state_nxt;
  logic [BW-1:0]           clk_cnt, clk_cnt_nxt;
  logic [2:0]              bit_idx, bit_idx_nxt;
  logic [3:0]              ch_sel, ch_sel_nxt;
  logic [3:0]              dig_sel, dig_sel_nxt;
  logic                    pending;
  logic [NUM_CH*CNT_W-1:0] shadow;
  logic [3:0]              nib;
  logic [7:0]              tx_byte;

  // A trigger arriving on the LOAD edge must survive, since the snapshot misses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      shadow  <= '0;
    end else begin
      if (state == S_LOAD) shadow <= counts;
      if (trig)                 pending <= 1'b1;
      else if (state == S_LOAD) pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      ch_sel  <= '0;
      dig_sel <= '0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      ch_sel  <= ch_sel_nxt;
      dig_sel <= dig_sel_nxt;
    end
  end

  // dig_sel walks the hex digits, then DIG is the separator slot (',' or CR) and DIG+1 is LF.
  always_comb begin
    nib     = 4'h0;
    tx_byte = 8'h0A;
    for (int c = 0; c < NUM_CH; c++)
      for (int d = 0; d < DIG; d++)
        if (ch_sel == 4'(c) && dig_sel == 4'(d))
          nib = shadow[c*CNT_W + (DIG-1-d)*4 +: 4];
    if (dig_sel < 4'(DIG))
      tx_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    else if (dig_sel == 4'(DIG))
      tx_byte = (ch_sel == 4'(NUM_CH - 1)) ? 8'h0D : 8'h2C;
  end

  // NEXT doubles as the final stop-bit cycle so consecutive bytes have no gap.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    ch_sel_nxt  = ch_sel;
    dig_sel_nxt = dig_sel;
    o_Tx_Serial = 1'b1;
    o_Tx_Active = 1'b0;
    o_Tx_Done   = 1'b0;
    case (state)
      S_IDLE: if (pending) state_nxt = S_LOAD;
      S_LOAD: begin
        state_nxt   = S_START;
        clk_cnt_nxt = '0;
        ch_sel_nxt  = '0;
        dig_sel_nxt = '0;
      end
      S_START: begin
        o_Tx_Serial = 1'b0;
        o_Tx_Active = 1'b1;
        if (clk_cnt == BIT_LAST) begin
          state_nxt   = S_DATA;
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
        end else begin
          clk_cnt_nxt = clk_cnt + BW'(1);
        end
      end
      S_DATA: begin
        o_Tx_Serial = tx_byte[bit_idx];
        o_Tx_Active = 1'b1;
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) state_nxt = S_STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          clk_cnt_nxt = clk_cnt + BW'(1);
        end
      end
      S_STOP: begin
        o_Tx_Active = 1'b1;
        if (clk_cnt == STOP_LAST) begin
          state_nxt   = S_NEXT;
          clk_cnt_nxt = '0;
        end else begin
          clk_cnt_nxt = clk_cnt + BW'(1);
        end
      end
      S_NEXT: begin
        o_Tx_Active = 1'b1;
        if (dig_sel == 4'(DIG + 1)) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt   = S_START;
          clk_cnt_nxt = '0;
          if (dig_sel == 4'(DIG) && ch_sel != 4'(NUM_CH - 1)) begin
            ch_sel_nxt  = ch_sel + 4'd1;
            dig_sel_nxt = '0;
          end else begin
            dig_sel_nxt = dig_sel + 4'd1;
          end
        end
      end
      S_DONE: begin
        o_Tx_Done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piggy_bank_multi.sv
// Scoreboard bench for piggy_bank_multi: stimulus pushes expected report frames,
// a UART monitor decodes the line and pops/compares each completed frame.
module tb_piggy_bank_multi;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 8;
  localparam int DEB       = 4;
  localparam int CPB       = 8;
  localparam int FRAME_CYC = 13 * 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  coin_in = 4'h0;
  logic        report_req = 1'b0;
  logic        clear_req = 1'b0;
  logic [31:0] counts;
  logic [3:0]  sat;
  logic        o_Tx_Active, o_Tx_Done, o_Tx_Serial;

  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    frames_seen = 0;
  int    start_count = 0;
  int    frame_start = 0;
  int    last_done = 0;
  bit    lenient = 1'b0;
  bit    check_gap = 1'b0;
  string exp_frames[$];
  string rx_str = "";
  string last_frame = "";

  piggy_bank_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEB_CYCLES(DEB), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .coin_in(coin_in),
    .report_req(report_req), .clear_req(clear_req), .counts(counts), .sat(sat),
    .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done), .o_Tx_Serial(o_Tx_Serial)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      byte c = s.getc(i);
      if (c == 8'h0D)      r = {r, "\\r"};
      else if (c == 8'h0A) r = {r, "\\n"};
      else                 r = $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic checkFrame(input string name, input string got, input string exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got \"%s\", expected \"%s\" (cycle %0d)", name, vis(got), vis(exp), cyc);
  endtask

  // sel 0..3 pulses a coin channel, sel 4 pulses report_req
  task automatic applyStimulus(input int sel, input int hi, input int lo);
    @(negedge clk);
    if (sel < 4) coin_in[sel] = 1'b1; else report_req = 1'b1;
    repeat (hi) @(negedge clk);
    if (sel < 4) coin_in[sel] = 1'b0; else report_req = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_wait", 32'(frames_seen >= target), 32'd1);
  endtask

  task automatic waitActive(input int budget);
    int n = 0;
    while (!o_Tx_Active && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("active_wait", 32'(o_Tx_Active), 32'd1);
  endtask

  // UART receiver: samples each bit at its centre and assembles frames up to LF.
  initial begin : uart_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && !o_Tx_Serial) begin
        start_count++;
        if (rx_str.len() == 0) begin
          frame_start = cyc;
          if (check_gap) begin
            check_gap = 1'b0;
            checkOutput("b2b_gap", 32'(cyc - last_done), 32'd3);
          end
        end
        repeat (CPB / 2) @(negedge clk);
        checkOutput("start_bit", 32'(o_Tx_Serial), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = o_Tx_Serial;
        end
        repeat (CPB) @(negedge clk);
        checkOutput("stop_bit", 32'(o_Tx_Serial), 32'd1);
        rx_str = $sformatf("%s%c", rx_str, b);
        if (b == 8'h0A) begin
          frames_seen++;
          last_frame = rx_str;
          if (!lenient) begin
            if (exp_frames.size() == 0) checkFrame("unexpected_frame", rx_str, "<none>");
            else                        checkFrame("frame", rx_str, exp_frames.pop_front());
          end
          rx_str = "";
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (rst_n && o_Tx_Done) begin
        checkOutput("done_gap", 32'(cyc - frame_start), 32'(FRAME_CYC));
        checkOutput("active_low_at_done", 32'(o_Tx_Active), 32'd0);
        last_done = cyc;
      end
    end
  end

  initial begin : main
    int base;
    int fs;

    // reset with random inputs
    repeat (5) begin
      @(negedge clk);
      coin_in    = 4'($urandom);
      report_req = 1'($urandom);
      clear_req  = 1'($urandom);
      ena        = 1'($urandom);
    end
    checkOutput("rst_counts", counts, 32'h0);
    checkOutput("rst_sat", 32'(sat), 32'h0);
    checkOutput("rst_serial", 32'(o_Tx_Serial), 32'd1);
    checkOutput("rst_active", 32'(o_Tx_Active), 32'd0);
    checkOutput("rst_done", 32'(o_Tx_Done), 32'd0);
    @(negedge clk);
    coin_in = 4'h0; report_req = 1'b0; clear_req = 1'b0; ena = 1'b1; rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("idle_serial", 32'(o_Tx_Serial), 32'd1);
    checkOutput("idle_no_start", 32'(start_count), 32'd0);

    // single coin on channel 2, latency DEB+3 edges
    exp_frames.push_back("00,00,01,00\r\n");
    @(negedge clk);
    coin_in[2] = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    checkOutput("ch2_before_latency", 32'(counts[23:16]), 32'd0);
    @(negedge clk);
    checkOutput("ch2_at_latency", 32'(counts[23:16]), 32'd1);
    repeat (3) @(negedge clk);
    coin_in[2] = 1'b0;
    waitFrames(1, 1500);

    // bounce rejection, then a clean pulse
    base = start_count;
    repeat (5) applyStimulus(1, 3, 6);
    repeat (50) @(negedge clk);
    checkOutput("ch1_after_bounce", 32'(counts[15:8]), 32'd0);
    checkOutput("no_frame_after_bounce", 32'(start_count - base), 32'd0);
    exp_frames.push_back("00,01,01,00\r\n");
    applyStimulus(1, 6, 10);
    checkOutput("ch1_clean", 32'(counts[15:8]), 32'd1);
    waitFrames(2, 1500);

    // saturation on channel 0
    lenient = 1'b1;
    repeat (256) applyStimulus(0, 6, 6);
    repeat (2400) @(negedge clk);
    checkOutput("sat_counts", counts, 32'h000101FF);
    checkOutput("sat_flag", 32'(sat), 32'h1);
    checkFrame("sat_last_frame", last_frame, "FF,01,01,00\r\n");
    checkOutput("sat_line_idle", 32'(o_Tx_Active), 32'd0);
    base = start_count;
    applyStimulus(0, 6, 6);
    repeat (60) @(negedge clk);
    checkOutput("sat_hold_counts", counts, 32'h000101FF);
    checkOutput("sat_hold_flag", 32'(sat), 32'h1);
    checkOutput("sat_no_retrigger", 32'(start_count - base), 32'd0);
    lenient = 1'b0;

    // clear in the same cycle as a channel 3 coin event
    exp_frames.push_back("00,00,00,00\r\n");
    base = start_count;
    fs = frames_seen;
    @(negedge clk);
    coin_in[3] = 1'b1;
    repeat (DEB + 2) @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    checkOutput("clear_counts", counts, 32'h0);
    checkOutput("clear_sat", 32'(sat), 32'h0);
    repeat (3) @(negedge clk);
    coin_in[3] = 1'b0;
    waitFrames(fs + 1, 1500);
    repeat (100) @(negedge clk);
    checkOutput("clear_single_frame_bytes", 32'(start_count - base), 32'd13);

    // coalescing: three ch1 coins during a report frame
    fs = frames_seen;
    exp_frames.push_back("00,00,00,00\r\n");
    exp_frames.push_back("00,03,00,00\r\n");
    applyStimulus(4, 6, 6);
    waitActive(200);
    repeat (3) applyStimulus(1, 6, 6);
    check_gap = 1'b1;
    waitFrames(fs + 2, 2600);
    checkOutput("coalesce_ch1", 32'(counts[15:8]), 32'd3);

    // ena low: coins, clear and report ignored
    ena = 1'b0;
    base = start_count;
    applyStimulus(0, 6, 6);
    applyStimulus(2, 6, 6);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    applyStimulus(4, 6, 6);
    repeat (40) @(negedge clk);
    checkOutput("ena_low_counts", counts, 32'h00000300);
    checkOutput("ena_low_no_frame", 32'(start_count - base), 32'd0);

    // report request with no count change
    ena = 1'b1;
    fs = frames_seen;
    exp_frames.push_back("00,03,00,00\r\n");
    applyStimulus(4, 6, 6);
    waitFrames(fs + 1, 1500);

    // reset mid-frame
    lenient = 1'b1;
    applyStimulus(4, 6, 6);
    waitActive(200);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_serial", 32'(o_Tx_Serial), 32'd1);
    checkOutput("midrst_active", 32'(o_Tx_Active), 32'd0);
    base = start_count;
    fs = frames_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) @(negedge clk);
    checkOutput("midrst_no_bytes", 32'(start_count - base), 32'd0);
    checkOutput("midrst_no_frames", 32'(frames_seen - fs), 32'd0);
    checkOutput("midrst_counts", counts, 32'h0);

    checkOutput("scoreboard_empty", 32'(exp_frames.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
